grid_renderer: RTL and testbench
================================

Name: grid_renderer

Overview:
- Pipelined, parametrised pixel painter for the tile-grid game board, between the VGA timing generator and the DAC outputs.
- Maps each incoming pixel coordinate to a grid line, a cell, or the background, then colours it from a per-cell state code.
- Adds a blinking cursor highlight and win/lose grid-line colouring.
- Takes a per-frame snapshot of all inputs so board updates never tear mid-frame.

Parameters:
- COLS, 8, number of grid columns
- ROWS, 8, number of grid rows
- CELL_W, 75, cell interior width in pixels
- CELL_H, 55, cell interior height in pixels
- LINE_W, 4, grid line thickness in pixels (both axes)
- STATE_W, 4, bits per cell state code
- BLINK_FRAMES, 30, frames per blink half-period (≥1)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hs  in  10  current pixel column
- vs  in  10  current pixel row
- video_on  in  1  active-video flag aligned with hs/vs
- states  in  ROWS*COLS*STATE_W  packed cell states; cell k = row*COLS+col occupies bits [k*STATE_W +: STATE_W]
- cursor  in  $clog2(ROWS*COLS)  index of the selected cell
- win  in  1  game-won flag
- lose  in  1  game-lost flag
- video_on_o  out  1  video_on delayed to align with r/g/b
- r, g, b  out  8 each  pixel colour

Behaviour:
- Reset (reset=0, asynchronous): r/g/b=0, video_on_o=0, pipeline regs 0, shadow states all 0, shadow cursor 0, shadow win/lose 0, frame counter 0, blink=0.
- Geometry:
  - PITCH = CELL_W+LINE_W.
  - GW = COLS*PITCH+LINE_W; GH = ROWS*PITCH_V+LINE_W, where PITCH_V = CELL_H+LINE_W.
  - Background: hs≥GW or vs≥GH.
  - Line: otherwise, (hs mod PITCH)<LINE_W or (vs mod PITCH_V)<LINE_W.
  - Cell: otherwise; col = hs/PITCH, row = vs/PITCH_V (constant division, widths per $clog2).
- Frame start: a cycle with hs==0 and vs==0 whose previous cycle was not hs==0 and vs==0. Edge-detected, so a held (0,0) counts once.
- At frame start, on the same clock edge:
  - Latch states, cursor, win and lose into shadow registers.
  - Frame counter: if it equals BLINK_FRAMES-1, wrap to 0 and toggle blink; else increment.
  - All colour decisions use shadow values only.
- The frame-start pixel itself is painted from the newly latched shadow values. Stage 1 reads the shadows after they update.
- Pipeline latency: 2 cycles.
  - Stage 1 registers the classification (bg / line / cell), the cell index and video_on.
  - Stage 2 registers the final colour and video_on_o.
  - Outputs at cycle n+2 reflect inputs sampled at cycle n.
- Colour priority, in stage 2:
  1. video_on_d=0 or background → 0x000000.
  2. Line with shadow lose=1 → 0xFF0000 when blink=1, 0x202020 when blink=0 (flashing).
  3. Line with shadow win=1 and lose=0 → 0x00FF00 (steady).
  4. Line otherwise → 0x202020.
  5. Cell whose index == shadow cursor, with blink=1 and win=lose=0 → 0xFFFF00.
  6. Cell otherwise, by state code: 0 hidden → 0x808080; 1 revealed → 0xFFFFFF; 2 flag → 0xFF4000; 3 mine → 0x000000; 4..(2^STATE_W−1) numbered → 0x4040C0.
- win and lose both set: lose wins.
- Cursor index ≥ ROWS*COLS: no cell highlighted.
- Reset mid-frame clears shadows and blink. Painting resumes immediately with all cells hidden (0x808080) until the next frame start latches real states.
- hs/vs outside 0..1023 are impossible by width. Values beyond GW/GH are background.

Test Plan:
- Reset: hold reset=0 with video_on=1, hs=100, vs=100 → r/g/b=0, video_on_o=0. Release, states all 1, frame start, hs=100/vs=100 → 0xFFFFFF two cycles after the sample.
- Geometry, defaults (PITCH=79, PITCH_V=59): hs=79/vs=30 → 0x202020 (line); hs=83/vs=30 → cell 1 colour; hs=636/vs=30 → 0x000000 (GW=636); hs=30/vs=476 → 0x000000 (GH=476).
- No tearing: change cell 0 from 0 to 3 while hs=200/vs=200 → cell 0 stays 0x808080 until the next frame start, then 0x000000.
- Cursor blink:
  - cursor=9, cell 9 state 0, hs=100/vs=100 → 0x808080 for frames 1–29.
  - After the 30th frame start → 0xFFFF00 for 30 frames, then back.
- Win/lose:
  - win=1 → line pixel 0x00FF00.
  - win=1 and lose=1 → line alternates 0xFF0000 / 0x202020 every 30 frames; cursor highlight suppressed.
- Reset mid-frame: assert reset during an active line after states were latched → outputs 0 immediately. After release, cells show 0x808080 until the next frame start.

Source files
------------

// File: rtl/grid_renderer.sv
// grid_renderer: two-stage pixel painter for the tile-grid board, colouring lines,
// cells, cursor and win/lose state from a per-frame snapshot of the board inputs.
module grid_renderer #(
   parameter int COLS         = 8,
   parameter int ROWS         = 8,
   parameter int CELL_W       = 75,
   parameter int CELL_H       = 55,
   parameter int LINE_W       = 4,
   parameter int STATE_W      = 4,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [9:0]                         hs,
   input  logic [9:0]                         vs,
   input  logic                               video_on,
   input  logic [ROWS*COLS*STATE_W-1:0]       states,
   input  logic [$clog2(ROWS*COLS)-1:0]       cursor,
   input  logic                               win,
   input  logic                               lose,
   output logic                               video_on_o,
   output logic [7:0]                         r,
   output logic [7:0]                         g,
   output logic [7:0]                         b
);
   localparam int PITCH   = CELL_W + LINE_W;
   localparam int PITCH_V = CELL_H + LINE_W;
   localparam int GW      = COLS * PITCH + LINE_W;
   localparam int GH      = ROWS * PITCH_V + LINE_W;
   localparam int IW      = $clog2(ROWS * COLS);
   localparam int FW      = $clog2(BLINK_FRAMES + 1);
   logic [9:0]                   hcol, vrow;
   logic                         at0, pz, frame_start, bg, line;
   logic [IW-1:0]                idx;
   logic [ROWS*COLS*STATE_W-1:0] sh_states;
   logic [IW-1:0]                sh_cursor;
   logic                         sh_win, sh_lose, blink;
   logic [FW-1:0]                fc;
   logic                         s1_bg, s1_line, s1_von;
   logic [IW-1:0]                s1_idx;
   logic [STATE_W-1:0]           st;
   logic [23:0]                  rgb_c;
   assign hcol        = hs / 10'(PITCH);
   assign vrow        = vs / 10'(PITCH_V);
   assign bg          = int'(hs) >= GW || int'(vs) >= GH;
   assign line        = (hs % 10'(PITCH)) < 10'(LINE_W) || (vs % 10'(PITCH_V)) < 10'(LINE_W);
   assign idx         = IW'(vrow * 10'(COLS) + hcol);
   assign at0         = hs == 10'd0 && vs == 10'd0;
   assign frame_start = at0 && !pz;
   // Snapshot of board inputs, refreshed only at the first (0,0) pixel of a frame.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pz        <= 1'b0;
         sh_states <= '0;
         sh_cursor <= '0;
         sh_win    <= 1'b0;
         sh_lose   <= 1'b0;
         fc        <= '0;
         blink     <= 1'b0;
      end else begin
         pz <= at0;
         if (frame_start) begin
            sh_states <= states;
            sh_cursor <= cursor;
            sh_win    <= win;
            sh_lose   <= lose;
            fc        <= (fc == FW'(BLINK_FRAMES - 1)) ? '0 : fc + 1'b1;
            if (fc == FW'(BLINK_FRAMES - 1)) blink <= ~blink;
         end
      end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         s1_bg      <= 1'b0;
         s1_line    <= 1'b0;
         s1_idx     <= '0;
         s1_von     <= 1'b0;
         {r, g, b}  <= 24'h0;
         video_on_o <= 1'b0;
      end else begin
         s1_bg      <= bg;
         s1_line    <= line;
         s1_idx     <= idx;
         s1_von     <= video_on;
         {r, g, b}  <= rgb_c;
         video_on_o <= s1_von;
      end
   assign st = sh_states[s1_idx*STATE_W +: STATE_W];
   // Lose dominates win; the cursor highlight is suppressed once the game is over.
   always_comb begin
      rgb_c = 24'h000000;
      if (!s1_von || s1_bg)
         rgb_c = 24'h000000;
      else if (s1_line)
         rgb_c = sh_lose ? (blink ? 24'hFF0000 : 24'h202020) : sh_win ? 24'h00FF00 : 24'h202020;
      else if (s1_idx == sh_cursor && blink && !sh_win && !sh_lose)
         rgb_c = 24'hFFFF00;
      else
         rgb_c = st == STATE_W'(0) ? 24'h808080 :
                 st == STATE_W'(1) ? 24'hFFFFFF :
                 st == STATE_W'(2) ? 24'hFF4000 :
                 st == STATE_W'(3) ? 24'h000000 : 24'h4040C0;
   end
endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: directed and randomised checks of grid_renderer against a
// frame-level reference model of the board snapshot, blink timing and colour rules.
module tb_grid_renderer;
   logic         clk = 1'b0;
   logic         reset;
   logic [9:0]   hs, vs;
   logic         video_on;
   logic [255:0] states;
   logic [5:0]   cursor;
   logic         win, lose;
   logic         video_on_o;
   logic [7:0]   r, g, b;
   int           errors = 0;
   int           checks = 0;
   logic [255:0] m_st;
   int           m_cur, m_fc;
   bit           m_win, m_lose, m_blink, m_pz;

   grid_renderer dut (
      .clk(clk), .reset(reset), .hs(hs), .vs(vs), .video_on(video_on),
      .states(states), .cursor(cursor), .win(win), .lose(lose),
      .video_on_o(video_on_o), .r(r), .g(g), .b(b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         if (hs == 0 && vs == 0 && !m_pz) begin
            m_st = states; m_cur = int'(cursor); m_win = win; m_lose = lose;
            if (m_fc == 29) begin m_fc = 0; m_blink = !m_blink; end
            else m_fc++;
         end
         m_pz = (hs == 0 && vs == 0);
      end
      #1;
   endtask

   task automatic model_clear();
      m_st = '0; m_cur = 0; m_win = 0; m_lose = 0; m_fc = 0; m_blink = 0; m_pz = 0;
   endtask

   function automatic logic [23:0] exp_col(input int h, input int v, input bit von);
      int idx, s;
      if (!von || h >= 636 || v >= 476) return 24'h000000;
      if (h % 79 < 4 || v % 59 < 4)
         return m_lose ? (m_blink ? 24'hFF0000 : 24'h202020) : m_win ? 24'h00FF00 : 24'h202020;
      idx = (v / 59) * 8 + h / 79;
      if (idx == m_cur && m_blink && !m_win && !m_lose) return 24'hFFFF00;
      s = int'((m_st >> (idx * 4)) & 256'hF);
      case (s)
         0: return 24'h808080;
         1: return 24'hFFFFFF;
         2: return 24'hFF4000;
         3: return 24'h000000;
         default: return 24'h4040C0;
      endcase
   endfunction

   task automatic frame();
      hs = 10'd1; vs = 10'd0; tick();
      hs = 10'd0; vs = 10'd0; tick();
   endtask

   task automatic paint(input int h, input int v, input bit von, input string tag);
      hs = 10'(h); vs = 10'(v); video_on = von;
      tick(); tick();
      check(tag, {r, g, b}, exp_col(h, v, von));
   endtask

   task automatic fill(input logic [3:0] val);
      for (int k = 0; k < 64; k++) states[k*4 +: 4] = val;
   endtask

   initial begin
      reset = 1'b0; hs = 10'd100; vs = 10'd100; video_on = 1'b1;
      states = '0; cursor = '0; win = 1'b0; lose = 1'b0;
      model_clear();
      repeat (3) tick();
      check("reset_rgb", {r, g, b}, 24'h000000);
      check("reset_von", {23'h0, video_on_o}, 24'h000000);
      reset = 1'b1;
      fill(4'd1);
      frame();
      hs = 10'd100; vs = 10'd100; tick(); tick();
      check("first_frame_revealed", {r, g, b}, 24'hFFFFFF);
      check("von_o_after_2", {23'h0, video_on_o}, 24'h000001);
      // Geometry boundaries
      hs = 10'd79; vs = 10'd30; tick(); tick();
      check("vline_79", {r, g, b}, 24'h202020);
      paint(83, 30, 1, "cell1_83");
      check("cell1_const", {r, g, b}, 24'hFFFFFF);
      paint(82, 30, 1, "vline_82");
      paint(636, 30, 1, "bg_gw");
      check("bg_gw_const", {r, g, b}, 24'h000000);
      paint(635, 30, 1, "last_line_635");
      paint(30, 476, 1, "bg_gh");
      paint(30, 475, 1, "last_line_475");
      paint(100, 100, 0, "video_off");
      check("von_o_off", {23'h0, video_on_o}, 24'h000000);
      // No tearing: cell 0 change is invisible until the next frame start
      fill(4'd1); states[3:0] = 4'd0;
      frame();
      states[3:0] = 4'd3;
      paint(10, 10, 1, "tear_old");
      check("tear_old_const", {r, g, b}, 24'h808080);
      frame();
      paint(10, 10, 1, "tear_new");
      check("tear_new_const", {r, g, b}, 24'h000000);
      // Held (0,0) is a single frame start
      hs = 10'd1; vs = 10'd0; tick();
      hs = 10'd0; vs = 10'd0; repeat (3) tick();
      paint(200, 200, 1, "held_origin");
      // Randomised frames and pixels
      for (int f = 0; f < 8; f++) begin
         for (int w = 0; w < 8; w++) states[w*32 +: 32] = $urandom;
         cursor = 6'($urandom_range(0, 63));
         win = ($urandom_range(0, 3) == 0);
         lose = ($urandom_range(0, 3) == 0);
         frame();
         for (int p = 0; p < 8; p++) begin
            int h, v;
            h = $urandom_range(0, 700);
            v = $urandom_range(0, 520);
            if (h == 0 && v == 0) h = 1;
            paint(h, v, ($urandom_range(0, 7) != 0), "rand_pix");
         end
         paint(int'(cursor % 8) * 79 + 40, int'(cursor / 8) * 59 + 30, 1, "rand_cursor");
      end
      // Cursor blink from a clean frame counter
      reset = 1'b0; #1; model_clear();
      reset = 1'b1;
      win = 1'b0; lose = 1'b0; cursor = 6'd9; fill(4'd0);
      for (int f = 1; f <= 60; f++) begin
         frame();
         hs = 10'd93; vs = 10'd73; video_on = 1'b1; tick(); tick();
         check("cursor_blink", {r, g, b}, (f >= 30 && f < 60) ? 24'hFFFF00 : 24'h808080);
      end
      // Win: steady green lines
      win = 1'b1;
      frame();
      paint(79, 30, 1, "win_line");
      check("win_line_const", {r, g, b}, 24'h00FF00);
      // Win and lose: lose colouring flashes, cursor suppressed
      lose = 1'b1;
      for (int f = 62; f <= 91; f++) begin
         frame();
         hs = 10'd79; vs = 10'd30; tick(); tick();
         check("lose_line", {r, g, b}, (f >= 90) ? 24'hFF0000 : 24'h202020);
         if (f >= 90) begin
            hs = 10'd93; vs = 10'd73; tick(); tick();
            check("lose_no_cursor", {r, g, b}, 24'h808080);
         end
      end
      // Reset in the middle of an active line
      win = 1'b0; lose = 1'b0; fill(4'd2);
      frame();
      paint(10, 10, 1, "pre_reset_flag");
      check("pre_reset_const", {r, g, b}, 24'hFF4000);
      reset = 1'b0; #1; model_clear();
      check("midreset_rgb", {r, g, b}, 24'h000000);
      check("midreset_von", {23'h0, video_on_o}, 24'h000000);
      #2 reset = 1'b1;
      paint(10, 10, 1, "post_reset_hidden");
      check("post_reset_const", {r, g, b}, 24'h808080);
      frame();
      paint(10, 10, 1, "post_reset_relatch");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
